// File: rtl/icache_refill_controller_pkg.sv
// ---------------------------------------------------------------------------
// icache_refill_controller_pkg
//
// Shared fetch-side definitions for the instruction-cache refill path:
//   - default geometry of the cache line (offset, index and tag widths)
//   - default memory return bus width and the derived line size in bits
//   - the refill sequencer state encoding
//   - a helper that turns an offset width into a line size in bits
// ---------------------------------------------------------------------------
package icache_refill_controller_pkg;

   // Default line geometry: 32-byte lines, 256 sets, 64-bit addresses.
   localparam int unsigned defOffsetSize      = 5;
   localparam int unsigned defIndexSize       = 8;
   localparam int unsigned defTagSize         = 64 - (defOffsetSize + defIndexSize);
   localparam int unsigned defMemBusWidthBits = 64;

   // Line size in bits for a line of 2**offsetBits bytes.
   function automatic int unsigned cachelineBits(input int unsigned offsetBits);
      return (2 ** offsetBits) * 8;
   endfunction

   localparam int unsigned defCachelineSizeBits = cachelineBits(defOffsetSize);

   // Refill sequencer states. The hit/miss stage and debug tooling decode
   // these values, so the encoding is fixed explicitly.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      FILL   = 3'd2,
      UPDATE = 3'd3,
      DONE   = 3'd4
   } refillState_e;

endpackage

// File: rtl/icache_refill_controller_line_assembly_buffer.sv
// ---------------------------------------------------------------------------
// line_assembly_buffer
//
// Collects the beats of one cacheline refill into a line register.
// The first beat lands in the most-significant slice of the line, so the
// assembled line reads as {beat0, beat1, ..., beatN-1}.
//
// Ports:
//   clock_i      system clock
//   reset_i      synchronous active-high reset (counter and line to 0)
//   clear_i      restart assembly at beat 0 (line contents are left alone)
//   beatWrite_i  write data_i into the current beat slot and advance
//   data_i       one memory return beat
//   lastBeat_o   the beat slot being pointed at is the final one of the line
//   line_o       the assembled line
// ---------------------------------------------------------------------------
module line_assembly_buffer
   import icache_refill_controller_pkg::*;
#(
   parameter int unsigned memBusWidthBits = defMemBusWidthBits,
   parameter int unsigned beatsPerLine    = defCachelineSizeBits / defMemBusWidthBits
) (
   input  logic                                    clock_i,
   input  logic                                    reset_i,
   input  logic                                    clear_i,
   input  logic                                    beatWrite_i,
   input  logic [memBusWidthBits-1:0]              data_i,
   output logic                                    lastBeat_o,
   output logic [beatsPerLine*memBusWidthBits-1:0] line_o
);

   localparam int unsigned countWidth = (beatsPerLine > 1) ? $clog2(beatsPerLine) : 1;
   localparam int unsigned lineBits   = beatsPerLine * memBusWidthBits;

   logic [countWidth-1:0] beatCount_q;
   logic [lineBits-1:0]   line_q;

   // Beat counter and line storage. A clear only rewinds the counter: the
   // old line bytes are about to be overwritten beat by beat anyway, and
   // the controller never publishes the line before every slot is refreshed.
   // Beat k goes to the k-th slice counted down from the MSB.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         beatCount_q <= '0;
         line_q      <= '0;
      end else if (clear_i) begin
         beatCount_q <= '0;
      end else if (beatWrite_i) begin
         for (int k = 0; k < int'(beatsPerLine); k++) begin
            if (beatCount_q == countWidth'(k)) begin
               line_q[lineBits-1-k*memBusWidthBits -: memBusWidthBits] <= data_i;
            end
         end
         beatCount_q <= beatCount_q + countWidth'(1);
      end
   end

   assign lastBeat_o = (beatCount_q == countWidth'(beatsPerLine - 1));
   assign line_o     = line_q;

endmodule

// File: rtl/icache_refill_controller.sv
// ---------------------------------------------------------------------------
// icache_refill_controller
//
// Sequences instruction-cache miss refills for the 4-stage fetch unit.
// A miss from the hit/miss-check stage is latched, a single line request
// is issued to memory, the returned beats are assembled into a full line,
// and the line is written into the cache with a one-cycle update strobe.
// Fetch is held stalled from miss accept until the refill has retired.
//
// Ports:
//   clock_i              system clock
//   reset_i              synchronous active-high reset
//   flushPipeline_i      pipeline flush (aborts a request not yet accepted)
//   isCacheMiss_i        miss pending from hit/miss-check stage (level)
//   missTag_i            tag of the missing line
//   missIndex_i          index of the missing line
//   missOffset_i         offset of the missing fetch
//   memReq_o             line request valid
//   memAddr_o            line-aligned byte address {tag, index, 0}
//   memReqAck_i          memory accepted the request
//   memDataValid_i       return beat valid
//   memData_i            return beat
//   cacheUpdateEnable_o  one-cycle cache write strobe (also resolves the miss)
//   newTag_o             refill tag
//   newIndex_o           refill index
//   newOffset_o          original miss offset
//   newCacheline_o       assembled line, first beat in the MSBs
//   fetchStall_o         hold the fetch PC
//   missCount_o          saturating count of retired refills
// ---------------------------------------------------------------------------
module icache_refill_controller
   import icache_refill_controller_pkg::*;
#(
   parameter int unsigned offsetSize      = defOffsetSize,
   parameter int unsigned indexSize       = defIndexSize,
   parameter int unsigned tagSize         = 64 - (offsetSize + indexSize),
   parameter int unsigned memBusWidthBits = defMemBusWidthBits,
   parameter int unsigned beatsPerLine    = cachelineBits(offsetSize) / memBusWidthBits
) (
   input  logic                                 clock_i,
   input  logic                                 reset_i,
   input  logic                                 flushPipeline_i,
   input  logic                                 isCacheMiss_i,
   input  logic [tagSize-1:0]                   missTag_i,
   input  logic [indexSize-1:0]                 missIndex_i,
   input  logic [offsetSize-1:0]                missOffset_i,
   output logic                                 memReq_o,
   output logic [63:0]                          memAddr_o,
   input  logic                                 memReqAck_i,
   input  logic                                 memDataValid_i,
   input  logic [memBusWidthBits-1:0]           memData_i,
   output logic                                 cacheUpdateEnable_o,
   output logic [tagSize-1:0]                   newTag_o,
   output logic [indexSize-1:0]                 newIndex_o,
   output logic [offsetSize-1:0]                newOffset_o,
   output logic [cachelineBits(offsetSize)-1:0] newCacheline_o,
   output logic                                 fetchStall_o,
   output logic [31:0]                          missCount_o
);

   localparam int unsigned lineBits = cachelineBits(offsetSize);

   refillState_e state_q, state_d;

   logic                  missLoad;
   logic                  bufClear;
   logic                  beatWrite;
   logic                  lastBeat;
   logic [lineBits-1:0]   assembledLine;

   logic [tagSize-1:0]    missTag_q;
   logic [indexSize-1:0]  missIndex_q;
   logic [offsetSize-1:0] missOffset_q;

   logic [tagSize-1:0]    newTag_q;
   logic [indexSize-1:0]  newIndex_q;
   logic [offsetSize-1:0] newOffset_q;
   logic [lineBits-1:0]   newLine_q;

   logic                  fetchStall_q;
   logic [31:0]           missCount_q;

   line_assembly_buffer #(
      .memBusWidthBits (memBusWidthBits),
      .beatsPerLine    (beatsPerLine)
   ) u_lineBuffer (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .clear_i     (bufClear),
      .beatWrite_i (beatWrite),
      .data_i      (memData_i),
      .lastBeat_o  (lastBeat),
      .line_o      (assembledLine)
   );

   // Next-state and control decode for the refill sequencer.
   // In REQ an acknowledge takes priority over a flush: once memory has
   // accepted the request its beats will arrive regardless, so the fill has
   // to run to completion. For the same reason a flush is ignored in FILL.
   // The DONE guard cycle lets the hit/miss stage clear its miss level
   // (it reacts to the update strobe) before IDLE samples it again.
   always_comb begin
      state_d   = state_q;
      missLoad  = 1'b0;
      bufClear  = 1'b0;
      beatWrite = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (isCacheMiss_i && !flushPipeline_i) begin
               missLoad = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (memReqAck_i) begin
               bufClear = 1'b1;
               state_d  = FILL;
            end else if (flushPipeline_i) begin
               state_d  = IDLE;
            end
         end
         FILL: begin
            if (memDataValid_i) begin
               beatWrite = 1'b1;
               if (lastBeat) begin
                  state_d = UPDATE;
               end
            end
         end
         UPDATE: begin
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register, miss capture, stall flag, published refill fields and
   // the retired-refill counter. The published fields are captured during
   // UPDATE so that they keep showing the last refill while the next miss
   // is being serviced. The stall is registered from the next state so it
   // rises together with memReq_o and falls as soon as IDLE is re-entered.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         fetchStall_q <= 1'b0;
         missTag_q    <= '0;
         missIndex_q  <= '0;
         missOffset_q <= '0;
         newTag_q     <= '0;
         newIndex_q   <= '0;
         newOffset_q  <= '0;
         newLine_q    <= '0;
         missCount_q  <= '0;
      end else begin
         state_q      <= state_d;
         fetchStall_q <= (state_d != IDLE);
         if (missLoad) begin
            missTag_q    <= missTag_i;
            missIndex_q  <= missIndex_i;
            missOffset_q <= missOffset_i;
         end
         if (state_q == UPDATE) begin
            newTag_q    <= missTag_q;
            newIndex_q  <= missIndex_q;
            newOffset_q <= missOffset_q;
            newLine_q   <= assembledLine;
            if (missCount_q != 32'hFFFF_FFFF) begin
               missCount_q <= missCount_q + 32'd1;
            end
         end
      end
   end

   // During UPDATE the freshly assembled line and the latched miss fields
   // go straight out alongside the strobe; at all other times the values
   // captured from the previous UPDATE are presented.
   always_comb begin
      memReq_o            = (state_q == REQ);
      memAddr_o           = 64'({missTag_q, missIndex_q, {offsetSize{1'b0}}});
      cacheUpdateEnable_o = (state_q == UPDATE);
      fetchStall_o        = fetchStall_q;
      missCount_o         = missCount_q;
      if (state_q == UPDATE) begin
         newTag_o       = missTag_q;
         newIndex_o     = missIndex_q;
         newOffset_o    = missOffset_q;
         newCacheline_o = assembledLine;
      end else begin
         newTag_o       = newTag_q;
         newIndex_o     = newIndex_q;
         newOffset_o    = newOffset_q;
         newCacheline_o = newLine_q;
      end
   end

endmodule

// File: tb/tb_icache_refill_controller.sv
// ---------------------------------------------------------------------------
// tb_icache_refill_controller
//
// Drives directed and randomized refills into icache_refill_controller and
// compares every visible output against a transaction-level expectation:
// a refill is "request at the line address until acked, then the line is
// the arriving valid beats in order, published the cycle after the last
// beat, with the retired count bumped".
// ---------------------------------------------------------------------------
module tb_icache_refill_controller;

   localparam int offsetSize = 5;
   localparam int indexSize  = 8;
   localparam int tagSize    = 64 - (offsetSize + indexSize);
   localparam int busBits    = 64;
   localparam int lineBits   = (2 ** offsetSize) * 8;
   localparam int beatsLine  = lineBits / busBits;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  flushPipeline;
   logic                  isCacheMiss;
   logic [tagSize-1:0]    missTag;
   logic [indexSize-1:0]  missIndex;
   logic [offsetSize-1:0] missOffset;
   logic                  memReq;
   logic [63:0]           memAddr;
   logic                  memReqAck;
   logic                  memDataValid;
   logic [busBits-1:0]    memData;
   logic                  cacheUpdateEnable;
   logic [tagSize-1:0]    newTag;
   logic [indexSize-1:0]  newIndex;
   logic [offsetSize-1:0] newOffset;
   logic [lineBits-1:0]   newCacheline;
   logic                  fetchStall;
   logic [31:0]           missCount;

   int checkCount = 0;
   int passCount  = 0;

   // Model of what the block should be presenting between updates.
   logic [31:0]           expCount     = '0;
   logic [lineBits-1:0]   expHeldLine  = '0;
   logic [tagSize-1:0]    expHeldTag   = '0;
   logic [indexSize-1:0]  expHeldIndex = '0;
   logic [offsetSize-1:0] expHeldOff   = '0;

   // Miss fields to present during DONE when chaining back-to-back misses.
   logic [tagSize-1:0]    chainTag;
   logic [indexSize-1:0]  chainIdx;
   logic [offsetSize-1:0] chainOff;

   icache_refill_controller dut (
      .clock_i             (clock),
      .reset_i             (reset),
      .flushPipeline_i     (flushPipeline),
      .isCacheMiss_i       (isCacheMiss),
      .missTag_i           (missTag),
      .missIndex_i         (missIndex),
      .missOffset_i        (missOffset),
      .memReq_o            (memReq),
      .memAddr_o           (memAddr),
      .memReqAck_i         (memReqAck),
      .memDataValid_i      (memDataValid),
      .memData_i           (memData),
      .cacheUpdateEnable_o (cacheUpdateEnable),
      .newTag_o            (newTag),
      .newIndex_o          (newIndex),
      .newOffset_o         (newOffset),
      .newCacheline_o      (newCacheline),
      .fetchStall_o        (fetchStall),
      .missCount_o         (missCount)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Hard stop in case the bench itself ever stops advancing.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [lineBits-1:0] randLine();
      logic [lineBits-1:0] l;
      for (int i = 0; i < lineBits / 32; i++) begin
         l[i*32 +: 32] = $urandom;
      end
      return l;
   endfunction

   // Line-aligned byte address computed arithmetically from tag and index.
   function automatic logic [63:0] lineAddress(input logic [tagSize-1:0] t, input logic [indexSize-1:0] i);
      return (64'(t) << (indexSize + offsetSize)) | (64'(i) << offsetSize);
   endfunction

   task automatic checkOutput(input string tag, input logic [lineBits-1:0] observed, input logic [lineBits-1:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one cycle of inputs and advance to just after the next edge.
   task automatic applyStimulus(input logic miss, input logic flush, input logic ack, input logic valid, input logic [63:0] data);
      isCacheMiss   = miss;
      flushPipeline = flush;
      memReqAck     = ack;
      memDataValid  = valid;
      memData       = data;
      @(posedge clock);
      #1;
   endtask

   task automatic checkHeld(input string where);
      checkOutput({where, "HoldLine"},  newCacheline, expHeldLine);
      checkOutput({where, "HoldTag"},   lineBits'(newTag), lineBits'(expHeldTag));
      checkOutput({where, "HoldIndex"}, lineBits'(newIndex), lineBits'(expHeldIndex));
      checkOutput({where, "HoldOff"},   lineBits'(newOffset), lineBits'(expHeldOff));
   endtask

   // One complete refill, starting and ending in an IDLE cycle.
   task automatic runRefill(input logic [tagSize-1:0] tag, input logic [indexSize-1:0] idx,
                            input logic [offsetSize-1:0] off, input int ackDelay,
                            input bit useMask, input logic [31:0] validMask,
                            input logic [lineBits-1:0] lineData, input bit flushOnAck,
                            input bit flushInFill, input bit chainNext);
      logic [63:0] expAddr;
      logic [63:0] data;
      logic        v;
      logic        flushNow;
      int          got;
      int          fillCycles;
      expAddr = lineAddress(tag, idx);

      checkOutput("idleReq", lineBits'(memReq), lineBits'(0));
      checkOutput("idleStall", lineBits'(fetchStall), lineBits'(0));
      checkOutput("idleNoUpd", lineBits'(cacheUpdateEnable), lineBits'(0));
      missTag    = tag;
      missIndex  = idx;
      missOffset = off;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), rand64());

      for (int i = 0; i <= ackDelay; i++) begin
         checkOutput("reqValid", lineBits'(memReq), lineBits'(1));
         checkOutput("reqAddr", lineBits'(memAddr), lineBits'(expAddr));
         checkOutput("reqStall", lineBits'(fetchStall), lineBits'(1));
         checkOutput("reqNoUpd", lineBits'(cacheUpdateEnable), lineBits'(0));
         applyStimulus(1'b1, 1'(flushOnAck && (i == ackDelay)), 1'(i == ackDelay),
                       1'($urandom_range(0, 1)), rand64());
      end

      got        = 0;
      fillCycles = 0;
      while (got < beatsLine) begin
         checkOutput("fillReqLow", lineBits'(memReq), lineBits'(0));
         checkOutput("fillStall", lineBits'(fetchStall), lineBits'(1));
         checkOutput("fillNoUpd", lineBits'(cacheUpdateEnable), lineBits'(0));
         checkOutput("fillHoldLine", newCacheline, expHeldLine);
         if (fillCycles >= 24)  v = 1'b1;
         else if (useMask)      v = validMask[fillCycles];
         else                   v = 1'($urandom_range(0, 2) != 0);
         data     = v ? lineData[lineBits-1-got*busBits -: busBits] : rand64();
         flushNow = flushInFill && (got >= 1);
         if (v) got++;
         fillCycles++;
         applyStimulus(1'b1, flushNow, 1'b0, v, data);
      end

      checkOutput("updStrobe", lineBits'(cacheUpdateEnable), lineBits'(1));
      checkOutput("updLine", newCacheline, lineData);
      checkOutput("updTag", lineBits'(newTag), lineBits'(tag));
      checkOutput("updIndex", lineBits'(newIndex), lineBits'(idx));
      checkOutput("updOffset", lineBits'(newOffset), lineBits'(off));
      checkOutput("updStall", lineBits'(fetchStall), lineBits'(1));
      checkOutput("updReqLow", lineBits'(memReq), lineBits'(0));
      expHeldLine  = lineData;
      expHeldTag   = tag;
      expHeldIndex = idx;
      expHeldOff   = off;
      if (expCount != 32'hFFFF_FFFF) expCount = expCount + 32'd1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), rand64());

      checkOutput("doneNoUpd", lineBits'(cacheUpdateEnable), lineBits'(0));
      checkOutput("doneStall", lineBits'(fetchStall), lineBits'(1));
      checkOutput("doneCount", lineBits'(missCount), lineBits'(expCount));
      checkHeld("done");
      if (chainNext) begin
         missTag    = chainTag;
         missIndex  = chainIdx;
         missOffset = chainOff;
      end
      applyStimulus(chainNext, 1'b0, 1'b0, 1'($urandom_range(0, 1)), rand64());

      checkOutput("postReqLow", lineBits'(memReq), lineBits'(0));
      checkOutput("postStall", lineBits'(fetchStall), lineBits'(0));
      checkOutput("postNoUpd", lineBits'(cacheUpdateEnable), lineBits'(0));
      checkOutput("postCount", lineBits'(missCount), lineBits'(expCount));
      checkHeld("post");
      if (!chainNext) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), rand64());
         checkOutput("noRetrigger", lineBits'(memReq), lineBits'(0));
      end
   endtask

   // A miss that is flushed before memory acknowledges must vanish quietly.
   task automatic runFlushInReq(input logic [tagSize-1:0] tag, input logic [indexSize-1:0] idx,
                                input logic [offsetSize-1:0] off);
      missTag    = tag;
      missIndex  = idx;
      missOffset = off;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, rand64());
      checkOutput("flushedMissIgnored", lineBits'(memReq), lineBits'(0));
      checkOutput("flushedMissNoStall", lineBits'(fetchStall), lineBits'(0));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, rand64());
      checkOutput("abortReqUp", lineBits'(memReq), lineBits'(1));
      checkOutput("abortAddr", lineBits'(memAddr), lineBits'(lineAddress(tag, idx)));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rand64());
      checkOutput("abortReqHeld", lineBits'(memReq), lineBits'(1));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, rand64());
      checkOutput("abortReqLow", lineBits'(memReq), lineBits'(0));
      checkOutput("abortNoStall", lineBits'(fetchStall), lineBits'(0));
      checkOutput("abortNoUpd", lineBits'(cacheUpdateEnable), lineBits'(0));
      checkOutput("abortCount", lineBits'(missCount), lineBits'(expCount));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), rand64());
      checkOutput("abortStillIdle", lineBits'(memReq), lineBits'(0));
      checkOutput("abortStillNoUpd", lineBits'(cacheUpdateEnable), lineBits'(0));
      checkHeld("abort");
   endtask

   // Reset lands after two beats of a fill; everything must read back as zero.
   task automatic runResetMidFill();
      missTag    = tagSize'(51'h2_BEEF);
      missIndex  = 8'h3C;
      missOffset = 5'h11;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, rand64());
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, rand64());
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, rand64());
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, rand64());
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, rand64());
      reset = 1'b0;
      expCount     = '0;
      expHeldLine  = '0;
      expHeldTag   = '0;
      expHeldIndex = '0;
      expHeldOff   = '0;
      checkOutput("rstReq", lineBits'(memReq), lineBits'(0));
      checkOutput("rstAddr", lineBits'(memAddr), lineBits'(0));
      checkOutput("rstStall", lineBits'(fetchStall), lineBits'(0));
      checkOutput("rstUpd", lineBits'(cacheUpdateEnable), lineBits'(0));
      checkOutput("rstCount", lineBits'(missCount), lineBits'(0));
      checkHeld("rst");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, rand64());
      checkOutput("rstIdle", lineBits'(memReq), lineBits'(0));
   endtask

   initial begin
      logic [63:0]         r;
      logic [lineBits-1:0] ld;
      reset         = 1'b1;
      flushPipeline = 1'b0;
      isCacheMiss   = 1'b0;
      missTag       = '0;
      missIndex     = '0;
      missOffset    = '0;
      memReqAck     = 1'b0;
      memDataValid  = 1'b0;
      memData       = '0;
      chainTag      = '0;
      chainIdx      = '0;
      chainOff      = '0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, rand64());
      checkOutput("resetReq", lineBits'(memReq), lineBits'(0));
      checkOutput("resetStall", lineBits'(fetchStall), lineBits'(0));
      checkOutput("resetUpd", lineBits'(cacheUpdateEnable), lineBits'(0));
      checkOutput("resetCount", lineBits'(missCount), lineBits'(0));
      checkHeld("reset");
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

      $display("[TB] basic refill");
      runRefill(tagSize'(51'h1234), 8'h05, 5'h0C, 0, 1'b1, 32'h0000_000F,
                {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD},
                1'b0, 1'b0, 1'b0);
      checkOutput("basicAddr", lineBits'(lineAddress(tagSize'(51'h1234), 8'h05)),
                  lineBits'(64'h0000_0000_0246_80A0));
      checkOutput("basicCount", lineBits'(missCount), lineBits'(1));

      $display("[TB] bubbles and late ack");
      runRefill(tagSize'(51'h7_0F0F), 8'hA5, 5'h1F, 3, 1'b1, 32'h0000_0059,
                randLine(), 1'b0, 1'b0, 1'b0);

      $display("[TB] flush in REQ");
      runFlushInReq(tagSize'(51'h55), 8'h11, 5'h02);

      $display("[TB] flush in FILL and flush with ack");
      runRefill(tagSize'(51'h1_2345), 8'hFF, 5'h00, 1, 1'b1, 32'h0000_00F5,
                randLine(), 1'b1, 1'b1, 1'b0);

      $display("[TB] reset mid-fill");
      runResetMidFill();
      runRefill(tagSize'(51'h3_3333), 8'h00, 5'h07, 0, 1'b0, 32'd0,
                randLine(), 1'b0, 1'b0, 1'b0);
      checkOutput("afterResetCount", lineBits'(missCount), lineBits'(1));

      $display("[TB] re-trigger guard and chained miss");
      chainTag = tagSize'(51'h4_4444);
      chainIdx = 8'h44;
      chainOff = 5'h04;
      runRefill(tagSize'(51'h6_6666), 8'h66, 5'h06, 0, 1'b1, 32'h0000_000F,
                randLine(), 1'b0, 1'b0, 1'b1);
      runRefill(chainTag, chainIdx, chainOff, 2, 1'b0, 32'd0,
                randLine(), 1'b0, 1'b0, 1'b0);

      $display("[TB] randomized refills");
      for (int n = 0; n < 30; n++) begin
         r  = rand64();
         ld = randLine();
         if ($urandom_range(0, 5) == 0) begin
            runFlushInReq(r[tagSize-1:0], r[63:56], r[4:0]);
         end else begin
            runRefill(r[tagSize-1:0], r[63:56], r[4:0], int'($urandom_range(0, 4)),
                      1'b0, 32'd0, ld, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
